// File: rtl/dm_pkg.sv
// Shared definitions for the DataMover tile scheduler: state encoding, command-word
// field constants and the 72-bit command builder.
package dm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_S2MM = 3'd1;
    localparam state_t ST_MM2S = 3'd2;
    localparam state_t ST_WAIT = 3'd3;
    localparam state_t ST_NEXT = 3'd4;
    localparam state_t ST_FIN  = 3'd5;

    localparam int unsigned CMD_W  = 72;
    localparam int unsigned BTT_W  = 23;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 4;

    localparam logic DM_INCR = 1'b1;
    localparam logic DM_EOF  = 1'b1;
    localparam logic DM_DRR  = 1'b1;

    // {rsvd[71:68], tag[67:64], addr[63:32], DRR, EOF, dsa[29:24], INCR, btt[22:0]}
    function automatic logic [CMD_W-1:0] build_cmd(
        input logic [BTT_W-1:0]  btt,
        input logic [ADDR_W-1:0] addr,
        input logic [TAG_W-1:0]  tag
    );
        return {4'b0000, tag, addr, DM_DRR, DM_EOF, 6'b000000, DM_INCR, btt};
    endfunction

endpackage

// File: rtl/dm_tile_sched.sv
// Issues one S2MM then one MM2S DataMover command per tile and waits for the tile's
// final output beat, counting beats to flag short or overlong tiles.
module dm_tile_sched
    import dm_pkg::*;
#(
    parameter int unsigned NUM_TILES = 4,
    parameter logic [31:0] MM2S_BASE = 32'h6000_0000,
    parameter logic [31:0] S2MM_BASE = 32'h7000_0000,
    parameter int unsigned MM2S_BTT  = 78000,
    parameter int unsigned S2MM_BTT  = 4800,
    parameter int unsigned OUT_BEATS = 1200
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic        m_axis_mm2s_cmd_tvalid,
    input  logic        m_axis_mm2s_cmd_tready,
    output logic [71:0] m_axis_mm2s_cmd_tdata,
    output logic        m_axis_s2mm_cmd_tvalid,
    input  logic        m_axis_s2mm_cmd_tready,
    output logic [71:0] m_axis_s2mm_cmd_tdata,
    input  logic        obs_tvalid,
    input  logic        obs_tready,
    input  logic        obs_tlast,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  tile_idx
);

    localparam int unsigned BEAT_W =
        ($clog2(OUT_BEATS + 1) > 11) ? $clog2(OUT_BEATS + 1) : 11;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(OUT_BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_SAT  = BEAT_W'(OUT_BEATS);
    localparam logic [3:0]        TILE_LAST = 4'(NUM_TILES - 1);
    localparam logic [31:0]       MM2S_STEP = 32'(MM2S_BTT);
    localparam logic [31:0]       S2MM_STEP = 32'(S2MM_BTT);
    localparam logic [22:0]       MM2S_BTT_F = 23'(MM2S_BTT);
    localparam logic [22:0]       S2MM_BTT_F = 23'(S2MM_BTT);

    state_t             state_q, state_d;
    logic [3:0]         tile_q, tile_d;
    logic [31:0]        mm2s_addr_q, mm2s_addr_d;
    logic [31:0]        s2mm_addr_q, s2mm_addr_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               err_q, err_d;
    logic               obs_hs;

    assign obs_hs = obs_tvalid & obs_tready;

    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        mm2s_addr_d = mm2s_addr_q;
        s2mm_addr_d = s2mm_addr_q;
        beat_d      = beat_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_S2MM;
                    tile_d      = '0;
                    mm2s_addr_d = MM2S_BASE;
                    s2mm_addr_d = S2MM_BASE;
                    beat_d      = '0;
                    err_d       = 1'b0;
                end
            end
            ST_S2MM: begin
                if (m_axis_s2mm_cmd_tready) state_d = ST_MM2S;
            end
            ST_MM2S: begin
                if (m_axis_mm2s_cmd_tready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (obs_hs) begin
                    if (obs_tlast) begin
                        if (beat_q != BEAT_LAST) begin
                            err_d   = 1'b1;
                            state_d = ST_FIN;
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end else if (beat_q != BEAT_SAT) begin
                        // Reaching the full count without tlast is already a mismatch.
                        beat_d = beat_q + 1'b1;
                        if (beat_q == BEAT_LAST) err_d = 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                if (tile_q == TILE_LAST) begin
                    state_d = ST_FIN;
                end else begin
                    state_d     = ST_S2MM;
                    tile_d      = tile_q + 4'd1;
                    mm2s_addr_d = mm2s_addr_q + MM2S_STEP;
                    s2mm_addr_d = s2mm_addr_q + S2MM_STEP;
                    beat_d      = '0;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort drops any pending command; the DataMover itself is reset elsewhere.
        if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            tile_q      <= '0;
            mm2s_addr_q <= '0;
            s2mm_addr_q <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_q      <= tile_d;
            mm2s_addr_q <= mm2s_addr_d;
            s2mm_addr_q <= s2mm_addr_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        m_axis_s2mm_cmd_tvalid = (state_q == ST_S2MM);
        m_axis_mm2s_cmd_tvalid = (state_q == ST_MM2S);
        m_axis_s2mm_cmd_tdata  = '0;
        m_axis_mm2s_cmd_tdata  = '0;
        if (m_axis_s2mm_cmd_tvalid) begin
            m_axis_s2mm_cmd_tdata = build_cmd(S2MM_BTT_F, s2mm_addr_q, tile_q);
        end
        if (m_axis_mm2s_cmd_tvalid) begin
            m_axis_mm2s_cmd_tdata = build_cmd(MM2S_BTT_F, mm2s_addr_q, tile_q);
        end
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_FIN);
        err      = err_q;
        tile_idx = tile_q;
    end

endmodule

// File: tb/tb_dm_tile_sched.sv
// Self-checking bench for dm_tile_sched: table of frame scenarios with randomized beat
// traffic, command words predicted from base + tile*BTT, plus abort and reset sequences.
module tb_dm_tile_sched;

    localparam int unsigned NUM_TILES = 4;
    localparam logic [31:0] MM2S_BASE = 32'h6000_0000;
    localparam logic [31:0] S2MM_BASE = 32'h7000_0000;
    localparam int unsigned MM2S_BTT  = 78000;
    localparam int unsigned S2MM_BTT  = 4800;
    localparam int unsigned OUT_BEATS = 1200;
    localparam int unsigned NONE      = 15;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mm2s_tvalid, s2mm_tvalid;
    logic        mm2s_tready = 1'b0;
    logic        s2mm_tready = 1'b0;
    logic [71:0] mm2s_tdata, s2mm_tdata;
    logic        obs_tvalid = 1'b0;
    logic        obs_tready = 1'b0;
    logic        obs_tlast = 1'b0;
    logic        busy, done, err;
    logic [3:0]  tile_idx;

    int checks = 0;
    int failures = 0;

    dm_tile_sched #(
        .NUM_TILES (NUM_TILES),
        .MM2S_BASE (MM2S_BASE),
        .S2MM_BASE (S2MM_BASE),
        .MM2S_BTT  (MM2S_BTT),
        .S2MM_BTT  (S2MM_BTT),
        .OUT_BEATS (OUT_BEATS)
    ) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .start                  (start),
        .abort                  (abort),
        .m_axis_mm2s_cmd_tvalid (mm2s_tvalid),
        .m_axis_mm2s_cmd_tready (mm2s_tready),
        .m_axis_mm2s_cmd_tdata  (mm2s_tdata),
        .m_axis_s2mm_cmd_tvalid (s2mm_tvalid),
        .m_axis_s2mm_cmd_tready (s2mm_tready),
        .m_axis_s2mm_cmd_tdata  (s2mm_tdata),
        .obs_tvalid             (obs_tvalid),
        .obs_tready             (obs_tready),
        .obs_tlast              (obs_tlast),
        .busy                   (busy),
        .done                   (done),
        .err                    (err),
        .tile_idx               (tile_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference command word, assembled field by field from the command layout.
    function automatic logic [71:0] ref_word(input int unsigned btt, input logic [31:0] base,
                                             input int unsigned tag);
        logic [71:0] w;
        w = '0;
        w[22:0]  = btt[22:0];
        w[23]    = 1'b1;
        w[30]    = 1'b1;
        w[31]    = 1'b1;
        w[63:32] = base + 32'(tag * btt);
        w[67:64] = tag[3:0];
        return w;
    endfunction

    // Passive monitor: records accepted commands, counts done cycles, checks that a
    // stalled command keeps tvalid and tdata until accepted (abort excepted).
    logic [71:0] s2mm_seen[$];
    logic [71:0] mm2s_seen[$];
    int          done_cnt = 0;
    logic        s_hold = 1'b0, m_hold = 1'b0, abort_prev = 1'b0;
    logic [71:0] s_prev, m_prev;

    always @(negedge clk) begin
        if (!rstn) begin
            s_hold = 1'b0;
            m_hold = 1'b0;
        end else begin
            if (s_hold && !abort_prev) begin
                check("s2mm_hold_valid", s2mm_tvalid, 1);
                check("s2mm_hold_data", s2mm_tdata, s_prev);
            end
            if (m_hold && !abort_prev) begin
                check("mm2s_hold_valid", mm2s_tvalid, 1);
                check("mm2s_hold_data", mm2s_tdata, m_prev);
            end
            if (s2mm_tvalid && s2mm_tready) s2mm_seen.push_back(s2mm_tdata);
            if (mm2s_tvalid && mm2s_tready) mm2s_seen.push_back(mm2s_tdata);
            if (done) done_cnt++;
            s_hold     = s2mm_tvalid && !s2mm_tready;
            m_hold     = mm2s_tvalid && !mm2s_tready;
            s_prev     = s2mm_tdata;
            m_prev     = mm2s_tdata;
            abort_prev = abort;
        end
    end

    task automatic wait_valid(input bit is_s2mm);
        int unsigned to = 0;
        while (!(is_s2mm ? s2mm_tvalid : mm2s_tvalid) && to < 20) begin
            tick();
            to++;
        end
        if (is_s2mm) check("s2mm_cmd_seen", s2mm_tvalid, 1);
        else         check("mm2s_cmd_seen", mm2s_tvalid, 1);
    endtask

    task automatic do_cmd(input bit is_s2mm, input int unsigned stall);
        wait_valid(is_s2mm);
        repeat (stall) tick();
        if (is_s2mm) s2mm_tready = 1'b1;
        else         mm2s_tready = 1'b1;
        tick();
        s2mm_tready = 1'b0;
        mm2s_tready = 1'b0;
        if (is_s2mm) check("s2mm_valid_after_hs", s2mm_tvalid, 0);
        else         check("mm2s_valid_after_hs", mm2s_tvalid, 0);
    endtask

    // Random beat traffic with idle and backpressured cycles plus stray start pulses;
    // tlast rides on the n-th handshake beat.
    task automatic send_beats(input int unsigned n);
        int unsigned sent = 0;
        int unsigned cyc = 0;
        bit v, r;
        while (sent < n && cyc < n * 16 + 64) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            obs_tvalid = v;
            obs_tready = r;
            obs_tlast  = (sent == n - 1);
            start      = ($urandom_range(0, 63) == 0);
            tick();
            cyc++;
            if (v && r) sent++;
        end
        obs_tvalid = 1'b0;
        obs_tready = 1'b0;
        obs_tlast  = 1'b0;
        start      = 1'b0;
        check("beats_sent", sent, n);
    endtask

    typedef struct {
        string       name;
        int unsigned short_tile;
        int unsigned short_len;
        int unsigned stall;
        int unsigned abort_tile;
        int unsigned exp_tiles;
        bit          exp_err;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int unsigned n, ns, nm;
        bit aborted = 0;
        s2mm_seen.delete();
        mm2s_seen.delete();
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({v.name, "_start_latency"}, s2mm_tvalid, 1);
        check({v.name, "_busy"}, busy, 1);
        check({v.name, "_err_cleared"}, err, 0);
        for (int t = 0; t < int'(v.exp_tiles); t++) begin
            do_cmd(1'b1, v.stall);
            check($sformatf("%s_tile_idx%0d", v.name, t), tile_idx, t);
            if (t == int'(v.abort_tile)) begin
                wait_valid(1'b0);
                repeat (2) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check({v.name, "_abort_valid"}, mm2s_tvalid, 0);
                check({v.name, "_abort_busy"}, busy, 0);
                check({v.name, "_abort_err"}, err, 0);
                aborted = 1;
                break;
            end
            do_cmd(1'b0, v.stall);
            n = (t == int'(v.short_tile)) ? v.short_len : OUT_BEATS;
            send_beats(n);
            if (n != OUT_BEATS) begin
                check($sformatf("%s_err_done%0d", v.name, t), done, 1);
            end else if (t == int'(v.exp_tiles) - 1) begin
                check({v.name, "_next_no_done"}, done, 0);
                check({v.name, "_next_busy"}, busy, 1);
                tick();
                check({v.name, "_fin_done"}, done, 1);
            end else begin
                check($sformatf("%s_mid_no_done%0d", v.name, t), done, 0);
            end
        end
        if (!aborted) begin
            check({v.name, "_err"}, err, v.exp_err);
            tick();
            check({v.name, "_idle_done"}, done, 0);
            check({v.name, "_idle_busy"}, busy, 0);
        end
        repeat (5) tick();
        check({v.name, "_done_count"}, done_cnt, aborted ? 0 : 1);
        ns = aborted ? v.abort_tile + 1 : v.exp_tiles;
        nm = aborted ? v.abort_tile : v.exp_tiles;
        check({v.name, "_s2mm_count"}, s2mm_seen.size(), ns);
        check({v.name, "_mm2s_count"}, mm2s_seen.size(), nm);
        for (int i = 0; i < s2mm_seen.size() && i < int'(ns); i++) begin
            check($sformatf("%s_s2mm_word%0d", v.name, i), s2mm_seen[i],
                  ref_word(S2MM_BTT, S2MM_BASE, i));
        end
        for (int i = 0; i < mm2s_seen.size() && i < int'(nm); i++) begin
            check($sformatf("%s_mm2s_word%0d", v.name, i), mm2s_seen[i],
                  ref_word(MM2S_BTT, MM2S_BASE, i));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_tile_idx"}, tile_idx, 0);
        check({tag, "_s2mm_valid"}, s2mm_tvalid, 0);
        check({tag, "_mm2s_valid"}, mm2s_tvalid, 0);
        check({tag, "_s2mm_data"}, s2mm_tdata, 0);
        check({tag, "_mm2s_data"}, mm2s_tdata, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{"nominal",  NONE, 0,    0, NONE, 4, 1'b0};
        vecs[1] = '{"short1",   1,    1000, 2, NONE, 2, 1'b1};
        vecs[2] = '{"abort2",   NONE, 0,    0, 2,    3, 1'b0};
        vecs[3] = '{"stall5",   NONE, 0,    5, NONE, 4, 1'b0};
        vecs[4] = '{"long0",    0,    1201, 1, NONE, 1, 1'b1};
        vecs[5] = '{"single3",  3,    1,    1, NONE, 4, 1'b1};

        repeat (3) tick();
        check_all_zero("in_reset");
        rstn = 1'b1;
        tick();
        check_all_zero("after_reset");

        // abort wins over a simultaneous start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start_busy", busy, 0);
        check("abort_beats_start_valid", s2mm_tvalid, 0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // asynchronous reset in the middle of a tile
        start = 1'b1;
        tick();
        start = 1'b0;
        do_cmd(1'b1, 0);
        do_cmd(1'b0, 0);
        obs_tvalid = 1'b1;
        obs_tready = 1'b1;
        repeat (50) tick();
        obs_tvalid = 1'b0;
        obs_tready = 1'b0;
        check("pre_reset_busy", busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("mid_wait_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_no_s2mm", s2mm_tvalid, 0);
            check("post_reset_no_mm2s", mm2s_tvalid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
